mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's instruction-fetch requester and its load/store requester.
- Grants one transaction at a time, tracks the single outstanding read, and routes returned data to its owner.
- Data access has priority. A streak counter guarantees fetch forward progress.
- Sits between the pipelined core and the unified instruction/data RAM.

---
 rtl/mem_port_arbiter_pkg.sv | 39 +++
 rtl/arb_streak_counter.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared bus definitions for the core-to-unified-RAM arbiter:
//   - default bus widths and the all-ones byte-enable constant for them
//   - arbiter state encoding (which read, if any, is outstanding)
//   - owner encoding (which requester a grant or a read return belongs to)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  // Full-word byte enables at the default data width; fetches always read
  // whole words.
  localparam logic [BUS_BE_W-1:0] BUS_BE_ALL = {BUS_BE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no read outstanding
    ST_WAIT_IF = 2'd1,  // fetch read outstanding
    ST_WAIT_D  = 2'd2   // load outstanding
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Which requester the currently outstanding read belongs to.
  function automatic owner_e state_owner(input arb_state_e st);
    case (st)
      ST_WAIT_IF: return OWN_IF;
      ST_WAIT_D:  return OWN_D;
      default:    return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// -----------------------------------------------------------------------------
// arb_streak_counter
// Saturating counter with synchronous clear. Counts consecutive data grants
// issued while fetch is waiting; at_max tells the arbiter to let fetch win.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one more (ignored once saturated)
//   clr        : return to zero (wins over inc)
//   at_max     : count has reached MAX_COUNT
// -----------------------------------------------------------------------------
module arb_streak_counter #(
  parameter int unsigned MAX_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign at_max = (count_q == CNT_W'(MAX_COUNT));

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch (if_*) and
// load/store (d_*). One transaction is granted per cycle at most; one read may
// be outstanding and its return is routed to its owner with no added latency.
// Data has priority, except that after MAX_STREAK consecutive data grants with
// fetch waiting, fetch wins the next arbitration.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   if_req/addr         : fetch read request (held until if_gnt)
//   if_gnt/rvalid/rdata : fetch accept and read return
//   d_req/we/addr/be/wdata : load/store request (held until d_gnt)
//   d_gnt/rvalid/rdata  : data accept and load return
//   mem_req/we/addr/be/wdata : RAM command strobe (valid on grant cycle)
//   mem_rvalid/rdata    : RAM read return, >=1 cycle after a read command
//   spurious_rvalid     : RAM returned data with no read outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                spurious_rvalid
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  owner_e     gnt_owner;
  owner_e     rd_owner;
  logic       port_free;
  logic       streak_max;
  logic       if_gnt_raw;
  logic       d_gnt_raw;

  // Counts data grants that bypassed a waiting fetch; any cycle without a
  // fetch request means fetch is not being starved, so the streak restarts.
  arb_streak_counter #(
    .MAX_COUNT (MAX_STREAK)
  ) u_streak (
    .clk    (clk),
    .reset  (reset),
    .inc    (d_gnt_raw && if_req),
    .clr    (if_gnt_raw || !if_req),
    .at_max (streak_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    gnt_owner       = OWN_NONE;
    state_d         = state_q;
    rd_owner        = state_owner(state_q);
    if_gnt          = 1'b0;
    d_gnt           = 1'b0;
    if_rvalid       = 1'b0;
    if_rdata        = '0;
    d_rvalid        = 1'b0;
    d_rdata         = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_be          = '0;
    mem_wdata       = '0;
    spurious_rvalid = 1'b0;

    // The outstanding read retires in the same cycle its data arrives, so a
    // new command can issue back-to-back with that return.
    port_free = (state_q == ST_IDLE) || mem_rvalid;

    if (port_free) begin
      if (if_req && (streak_max || !d_req)) begin
        gnt_owner = OWN_IF;
      end else if (d_req) begin
        gnt_owner = OWN_D;
      end
    end

    if_gnt_raw = (gnt_owner == OWN_IF);
    d_gnt_raw  = (gnt_owner == OWN_D);

    case (gnt_owner)
      OWN_IF:  state_d = ST_WAIT_IF;
      // Stores finish at grant: the RAM returns nothing for a write.
      OWN_D:   state_d = d_we ? ST_IDLE : ST_WAIT_D;
      default: if (mem_rvalid) state_d = ST_IDLE;
    endcase

    // Outputs are forced to zero for the whole reset interval, not just after
    // the next clock edge, so the RAM sees no command while reset is held.
    if (!reset) begin
      if_gnt  = if_gnt_raw;
      d_gnt   = d_gnt_raw;
      mem_req = if_gnt_raw || d_gnt_raw;

      if (if_gnt_raw) begin
        mem_addr = if_addr;
        mem_be   = {BE_W{1'b1}};
      end else if (d_gnt_raw) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end

      if (mem_rvalid) begin
        case (rd_owner)
          OWN_IF: begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          OWN_D: begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end
          default: spurious_rvalid = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (ADDR_W=32, DATA_W=32, MAX_STREAK=4).
// A vector table covers single-cycle behaviour; short hand-written sequences
// cover fetch starvation, reset during a read and back-to-back reads.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [3:0]  Z4  = 4'h0;
  localparam logic [3:0]  BF  = 4'hF;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } stim_t;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        spurious;
  } expv_t;

  typedef struct {
    stim_t s;
    expv_t e;
    string name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_rvalid, spurious_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STREAK (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_addr          (d_addr),
    .d_be            (d_be),
    .d_wdata         (d_wdata),
    .d_gnt           (d_gnt),
    .d_rvalid        (d_rvalid),
    .d_rdata         (d_rdata),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .spurious_rvalid (spurious_rvalid)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk_s(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [3:0] db,
                                 input logic [31:0] dd, input logic mv, input logic [31:0] md);
    return '{ir, ia, dr, dw, da, db, dd, mv, md};
  endfunction

  function automatic expv_t mk_e(input logic ig, input logic dg, input logic iv,
                                 input logic [31:0] ird, input logic dv, input logic [31:0] drd,
                                 input logic mr, input logic mw, input logic [31:0] ma,
                                 input logic [3:0] mb, input logic [31:0] mwd, input logic sp);
    return '{ig, dg, iv, ird, dv, drd, mr, mw, ma, mb, mwd, sp};
  endfunction

  task automatic apply(input stim_t s);
    if_req     = s.if_req;
    if_addr    = s.if_addr;
    d_req      = s.d_req;
    d_we       = s.d_we;
    d_addr     = s.d_addr;
    d_be       = s.d_be;
    d_wdata    = s.d_wdata;
    mem_rvalid = s.mem_rvalid;
    mem_rdata  = s.mem_rdata;
  endtask

  // strict=0 ignores the memory command fields when no command is expected,
  // and write data on a read command, since those carry no meaning then.
  task automatic compare(input expv_t e, input string name, input bit strict);
    expv_t a;
    a = '{if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
          mem_req, mem_we, mem_addr, mem_be, mem_wdata, spurious_rvalid};
    if (!strict && !e.mem_req) begin
      a.mem_we    = e.mem_we;
      a.mem_addr  = e.mem_addr;
      a.mem_be    = e.mem_be;
      a.mem_wdata = e.mem_wdata;
    end
    if (!strict && e.mem_req && !e.mem_we) a.mem_wdata = e.mem_wdata;
    check(name, 160'(a), 160'(e));
  endtask

  // Called at posedge+1: drive, check at posedge+4, advance to next posedge+1.
  task automatic step(input stim_t s, input expv_t e, input string name);
    apply(s);
    #3;
    compare(e, name, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Requester hold rule: while req=1 and no grant, the command must not move.
  logic        if_pend = 1'b0, d_pend = 1'b0;
  logic [31:0] if_hold;
  logic [68:0] d_hold;

  always @(negedge clk) begin
    if (!reset && if_pend && if_req) check("if_hold_stable", 160'(if_addr), 160'(if_hold));
    if (!reset && d_pend && d_req)
      check("d_hold_stable", 160'({d_we, d_addr, d_be, d_wdata}), 160'(d_hold));
    if_pend <= if_req && !if_gnt;
    if_hold <= if_addr;
    d_pend  <= d_req && !d_gnt;
    d_hold  <= {d_we, d_addr, d_be, d_wdata};
  end

  vec_t  tbl[10];
  stim_t s_idle;
  expv_t e_zero;

  initial begin
    s_idle = mk_s(L, Z32, L, L, Z32, Z4, Z32, L, Z32);
    e_zero = mk_e(L, L, L, Z32, L, Z32, L, L, Z32, Z4, Z32, L);

    tbl[0] = '{mk_s(H, 32'h100, L, L, Z32, Z4, Z32, L, Z32),
               mk_e(H, L, L, Z32, L, Z32, H, L, 32'h100, BF, Z32, L), "fetch_only_gnt"};
    tbl[1] = '{mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'hDEADBEEF),
               mk_e(L, L, H, 32'hDEADBEEF, L, Z32, L, L, Z32, Z4, Z32, L), "fetch_only_rdata"};
    tbl[2] = '{mk_s(H, 32'h104, H, L, 32'h200, BF, Z32, L, Z32),
               mk_e(L, H, L, Z32, L, Z32, H, L, 32'h200, BF, Z32, L), "simul_data_first"};
    tbl[3] = '{mk_s(H, 32'h104, L, L, Z32, Z4, Z32, H, 32'h12345678),
               mk_e(H, L, L, Z32, H, 32'h12345678, H, L, 32'h104, BF, Z32, L), "simul_drvalid_ifgnt"};
    tbl[4] = '{mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'hCAFEF00D),
               mk_e(L, L, H, 32'hCAFEF00D, L, Z32, L, L, Z32, Z4, Z32, L), "simul_if_rdata"};
    tbl[5] = '{mk_s(L, Z32, H, H, 32'h300, 4'b0100, 32'h00AB0000, L, Z32),
               mk_e(L, H, L, Z32, L, Z32, H, H, 32'h300, 4'b0100, 32'h00AB0000, L), "store_gnt"};
    tbl[6] = '{mk_s(H, 32'h108, L, L, Z32, Z4, Z32, L, Z32),
               mk_e(H, L, L, Z32, L, Z32, H, L, 32'h108, BF, Z32, L), "store_then_fetch"};
    tbl[7] = '{mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'h11112222),
               mk_e(L, L, H, 32'h11112222, L, Z32, L, L, Z32, Z4, Z32, L), "fetch_after_store_rdata"};
    tbl[8] = '{mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'h55AA55AA),
               mk_e(L, L, L, Z32, L, Z32, L, L, Z32, Z4, Z32, H), "idle_spurious"};
    tbl[9] = '{s_idle, e_zero, "idle_quiet"};

    // Reset: requests and a return present, yet every output must be zero.
    reset = 1'b1;
    apply(s_idle);
    @(posedge clk);
    #1;
    apply(mk_s(H, 32'h100, H, H, 32'h200, BF, 32'h1, H, 32'h99));
    #3;
    compare(e_zero, "reset_outputs", 1'b1);
    check("reset_streak", 160'(dut.u_streak.count_q), 160'(3'd0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step(tbl[i].s, tbl[i].e, tbl[i].name);

    // Starvation guard: fetch waits behind a run of stores.
    for (int k = 0; k < 4; k++) begin
      step(mk_s(H, 32'h400, H, H, 32'h500 + 32'(4 * k), 4'h3, 32'hA0 + 32'(k), L, Z32),
           mk_e(L, H, L, Z32, L, Z32, H, H, 32'h500 + 32'(4 * k), 4'h3, 32'hA0 + 32'(k), L),
           $sformatf("streak_store%0d", k));
    end
    check("streak_at_max", 160'(dut.u_streak.count_q), 160'(3'd4));
    step(mk_s(H, 32'h400, H, H, 32'h510, 4'h3, 32'hA4, L, Z32),
         mk_e(H, L, L, Z32, L, Z32, H, L, 32'h400, BF, Z32, L), "streak_fetch_wins");
    check("streak_cleared", 160'(dut.u_streak.count_q), 160'(3'd0));
    step(mk_s(L, Z32, H, H, 32'h510, 4'h3, 32'hA4, L, Z32), e_zero, "streak_port_busy");
    step(mk_s(L, Z32, H, H, 32'h510, 4'h3, 32'hA4, H, 32'hF00D0400),
         mk_e(L, H, H, 32'hF00D0400, L, Z32, H, H, 32'h510, 4'h3, 32'hA4, L), "streak_data_resumes");
    step(mk_s(L, Z32, H, H, 32'h514, 4'h3, 32'hA5, L, Z32),
         mk_e(L, H, L, Z32, L, Z32, H, H, 32'h514, 4'h3, 32'hA5, L), "streak_store5");
    step(s_idle, e_zero, "streak_done_idle");

    // Reset while a fetch read is outstanding, asserted between clock edges.
    step(mk_s(H, 32'h600, L, L, Z32, Z4, Z32, L, Z32),
         mk_e(H, L, L, Z32, L, Z32, H, L, 32'h600, BF, Z32, L), "rst_mid_fetch_gnt");
    apply(s_idle);
    #1;
    reset = 1'b1;
    apply(mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'h77));
    #1;
    compare(e_zero, "rst_mid_read_outputs", 1'b1);
    #2;
    reset = 1'b0;
    apply(s_idle);
    @(posedge clk);
    #1;
    step(mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'h88),
         mk_e(L, L, L, Z32, L, Z32, L, L, Z32, Z4, Z32, H), "late_rvalid_spurious");
    step(s_idle, e_zero, "after_spurious_quiet");

    // Three fetches, memory latency two cycles, each grant on the prior return.
    step(mk_s(H, 32'h700, L, L, Z32, Z4, Z32, L, Z32),
         mk_e(H, L, L, Z32, L, Z32, H, L, 32'h700, BF, Z32, L), "b2b_gnt0");
    for (int k = 1; k < 3; k++) begin
      step(mk_s(H, 32'h700 + 32'(4 * k), L, L, Z32, Z4, Z32, L, Z32), e_zero,
           $sformatf("b2b_wait%0d", k));
      step(mk_s(H, 32'h700 + 32'(4 * k), L, L, Z32, Z4, Z32, H, 32'hB0B00000 + 32'(k - 1)),
           mk_e(H, L, H, 32'hB0B00000 + 32'(k - 1), L, Z32, H, L, 32'h700 + 32'(4 * k), BF, Z32, L),
           $sformatf("b2b_ret%0d_gnt%0d", k - 1, k));
    end
    step(s_idle, e_zero, "b2b_wait_last");
    step(mk_s(L, Z32, L, L, Z32, Z4, Z32, H, 32'hB0B00002),
         mk_e(L, L, H, 32'hB0B00002, L, Z32, L, L, Z32, Z4, Z32, L), "b2b_ret2");
    step(s_idle, e_zero, "b2b_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
